// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: width codes, FSM and owner
// enums, and the alignment/legality check used at grant time.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} arb_state_t;
  typedef enum logic {OWN_CORE = 1'b0, OWN_DMA = 1'b1} owner_t;

  // Illegal width code or address not naturally aligned for the access size
  function automatic logic cmd_err(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: cmd_err = 1'b0;
      F3_H, F3_HU: cmd_err = lo[0];
      F3_W:        cmd_err = |lo;
      default:     cmd_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_load_extend.sv
// Load data extraction: picks the byte/halfword lane from the raw aligned word
// and sign- or zero-extends it according to funct3.
module load_extend
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = word[{addr_lo, 3'b000} +: 8];
    half_c = word[{addr_lo[1], 4'b0000} +: 16];
    data_c = word;
    case (funct3)
      F3_B:    data_c = DATA_W'($signed(byte_c));
      F3_H:    data_c = DATA_W'($signed(half_c));
      F3_BU:   data_c = DATA_W'(byte_c);
      F3_HU:   data_c = DATA_W'(half_c);
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter and access sequencer for the single-ported datamemory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is core priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [DM_ADDRESS-1:0] c_addr,
  input  logic [2:0]            c_funct3,
  input  logic [DATA_W-1:0]     c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_W-1:0]     c_rdata,
  output logic                  c_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DM_ADDRESS-1:0] d_addr,
  input  logic [2:0]            d_funct3,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  m_MemRead,
  output logic                  m_MemWrite,
  output logic [DM_ADDRESS-1:0] m_a,
  output logic [DATA_W-1:0]     m_wd,
  output logic [2:0]            m_Funct3,
  input  logic [DATA_W-1:0]     m_rd
);

  arb_state_t state, state_nx;
  owner_t     win_c, own_q;
  logic       grant_c;
  logic       we_q, err_q;

  logic                  sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [2:0]            sel_f3;
  logic [DATA_W-1:0]     sel_wd;
  logic                  sel_err;
  logic [DATA_W-1:0]     ext_c;
  logic [DATA_W-1:0]     rsp_data_c;

`ifdef DMEM_ARB_RR_EN
  owner_t last_q;
`endif

  // Winner selection, grant pulse and next state; grants are suppressed in reset
  always_comb begin
    state_nx = state;
    grant_c  = 1'b0;
    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
`ifdef DMEM_ARB_RR_EN
    win_c = (c_req && (!d_req || last_q == OWN_DMA)) ? OWN_CORE : OWN_DMA;
`else
    win_c = c_req ? OWN_CORE : OWN_DMA;
`endif
    case (state)
      IDLE: begin
        if (rst_n && (c_req || d_req)) begin
          grant_c  = 1'b1;
          c_gnt    = (win_c == OWN_CORE);
          d_gnt    = (win_c == OWN_DMA);
          state_nx = ACCESS;
        end
      end
      ACCESS:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    sel_we   = c_we;
    sel_addr = c_addr;
    sel_f3   = c_funct3;
    sel_wd   = c_wdata;
    if (win_c == OWN_DMA) begin
      sel_we   = d_we;
      sel_addr = d_addr;
      sel_f3   = d_funct3;
      sel_wd   = d_wdata;
    end
    sel_err = cmd_err(sel_f3, sel_addr[1:0]);
  end

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .funct3  (m_Funct3),
    .addr_lo (m_a[1:0]),
    .word    (m_rd),
    .data_c  (ext_c)
  );

  assign rsp_data_c = (we_q || err_q) ? '0 : ext_c;

  // Command latch at grant, one-cycle strobe in ACCESS, response one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_q      <= OWN_CORE;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      m_a        <= '0;
      m_wd       <= '0;
      m_Funct3   <= '0;
      m_MemRead  <= 1'b0;
      m_MemWrite <= 1'b0;
      c_rvalid   <= 1'b0;
      c_rdata    <= '0;
      c_err      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q     <= OWN_DMA;
`endif
    end else begin
      m_MemRead  <= 1'b0;
      m_MemWrite <= 1'b0;
      c_rvalid   <= 1'b0;
      c_rdata    <= '0;
      c_err      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
      if (grant_c) begin
        own_q      <= win_c;
        we_q       <= sel_we;
        err_q      <= sel_err;
        m_a        <= sel_addr;
        m_wd       <= sel_wd;
        m_Funct3   <= sel_f3;
        m_MemRead  <= !sel_we && !sel_err;
        m_MemWrite <= sel_we && !sel_err;
`ifdef DMEM_ARB_RR_EN
        last_q     <= win_c;
`endif
      end
      if (state == ACCESS) begin
        if (own_q == OWN_CORE) begin
          c_rvalid <= 1'b1;
          c_rdata  <= rsp_data_c;
          c_err    <= err_q;
        end else begin
          d_rvalid <= 1'b1;
          d_rdata  <= rsp_data_c;
          d_err    <= err_q;
        end
      end
    end
  end

endmodule
